// File: rtl/view_basis_sequencer_if.sv
// Request/response bus between the basis sequencer and the shared multi-cycle sin/cos unit.
// One request is outstanding at a time; the result strobe carries both sin and cos.
interface view_basis_sequencer_if #(
    parameter int unsigned ROTATE_B = 12,
    parameter int unsigned TRIG_B   = 16
);
    logic                     trig_req;
    logic [ROTATE_B-1:0]      trig_angle;
    logic                     trig_valid;
    logic signed [TRIG_B-1:0] trig_sin;
    logic signed [TRIG_B-1:0] trig_cos;

    modport master (
        output trig_req,
        output trig_angle,
        input  trig_valid,
        input  trig_sin,
        input  trig_cos
    );

    modport slave (
        input  trig_req,
        input  trig_angle,
        output trig_valid,
        output trig_sin,
        output trig_cos
    );
endinterface

// File: rtl/view_basis_sequencer.sv
// Computes the camera basis from yaw/pitch using a shared trig unit and one multiplier.
// Results sit in a shadow set and are committed to the outputs only at a frame boundary.
module view_basis_sequencer #(
    parameter int unsigned ROTATE_B        = 12,
    parameter int unsigned VECTOR_B        = 32,
    parameter int unsigned TRIG_B          = 16,
    parameter int unsigned FRAC            = 14,
    parameter bit          COMMIT_ON_FRAME = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ROTATE_B-1:0]           yaw,
    input  logic [ROTATE_B-1:0]           pitch,
    input  logic                          frame_start,
    view_basis_sequencer_if.master        trig,
    output logic                          busy,
    output logic                          pending,
    output logic [2:0][VECTOR_B-1:0]      x_vec,
    output logic [2:0][VECTOR_B-1:0]      y_vec,
    output logic [2:0][VECTOR_B-1:0]      z_vec
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ_Y   = 3'd1;
    localparam logic [2:0] WAIT_Y  = 3'd2;
    localparam logic [2:0] REQ_P   = 3'd3;
    localparam logic [2:0] WAIT_P  = 3'd4;
    localparam logic [2:0] MUL     = 3'd5;
    localparam logic [2:0] PENDING = 3'd6;

    localparam logic [VECTOR_B-1:0]      ZERO  = '0;
    localparam logic [VECTOR_B-1:0]      ONE   = VECTOR_B'(1) << FRAC;
    localparam logic [2:0][VECTOR_B-1:0] IDENT_X = {ZERO, ZERO, ONE};
    localparam logic [2:0][VECTOR_B-1:0] IDENT_Y = {ZERO, ONE, ZERO};
    localparam logic [2:0][VECTOR_B-1:0] IDENT_Z = {ONE, ZERO, ZERO};

    logic [2:0]               state_q, state_d;
    logic [1:0]               mul_cnt_q;
    logic [ROTATE_B-1:0]      last_yaw_q, last_pitch_q;
    logic signed [TRIG_B-1:0] sy_q, cy_q, sp_q, cp_q;
    logic [2:0][VECTOR_B-1:0] x_sh_q, y_sh_q, z_sh_q;

    logic start, cap_y, cap_p, commit;

    function automatic logic [VECTOR_B-1:0] sext(input logic signed [TRIG_B-1:0] v);
        return VECTOR_B'(v);
    endfunction

    // Shared multiplier: counter bit 1 picks the pitch term, bit 0 picks the yaw term,
    // giving the sequence sp*sy, sp*cy, cp*sy, cp*cy.
    logic signed [TRIG_B-1:0]   mul_a, mul_b;
    logic signed [2*TRIG_B-1:0] mul_full, mul_shr;
    logic signed [VECTOR_B-1:0] mul_res;

    assign mul_a    = mul_cnt_q[1] ? cp_q : sp_q;
    assign mul_b    = mul_cnt_q[0] ? cy_q : sy_q;
    assign mul_full = mul_a * mul_b;
    assign mul_shr  = mul_full >>> FRAC;
    assign mul_res  = VECTOR_B'(mul_shr);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cap_y   = 1'b0;
        cap_p   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (yaw != last_yaw_q || pitch != last_pitch_q) begin
                    start   = 1'b1;
                    state_d = REQ_Y;
                end
            end
            REQ_Y:  state_d = WAIT_Y;
            WAIT_Y: begin
                if (trig.trig_valid) begin
                    cap_y   = 1'b1;
                    state_d = REQ_P;
                end
            end
            REQ_P:  state_d = WAIT_P;
            WAIT_P: begin
                if (trig.trig_valid) begin
                    cap_p   = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mul_cnt_q == 2'd3) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_start || !COMMIT_ON_FRAME) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign trig.trig_req   = (state_q == REQ_Y) || (state_q == REQ_P);
    assign trig.trig_angle = (state_q == REQ_P) ? last_pitch_q : last_yaw_q;
    assign busy            = (state_q != IDLE) && (state_q != PENDING);
    assign pending         = (state_q == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_cnt_q    <= 2'd0;
            last_yaw_q   <= '0;
            last_pitch_q <= '0;
            sy_q         <= '0;
            cy_q         <= '0;
            sp_q         <= '0;
            cp_q         <= '0;
            x_sh_q       <= '0;
            y_sh_q       <= '0;
            z_sh_q       <= '0;
            x_vec        <= IDENT_X;
            y_vec        <= IDENT_Y;
            z_vec        <= IDENT_Z;
        end else begin
            state_q <= state_d;

            if (state_q == MUL) begin
                mul_cnt_q <= mul_cnt_q + 2'd1;
            end else begin
                mul_cnt_q <= 2'd0;
            end

            if (start) begin
                last_yaw_q   <= yaw;
                last_pitch_q <= pitch;
            end

            if (cap_y) begin
                sy_q <= trig.trig_sin;
                cy_q <= trig.trig_cos;
            end

            if (cap_p) begin
                sp_q <= trig.trig_sin;
                cp_q <= trig.trig_cos;
            end

            if (state_q == MUL) begin
                case (mul_cnt_q)
                    2'd0: begin
                        // Single-term components need no multiply; load them alongside.
                        x_sh_q[0] <= sext(cy_q);
                        x_sh_q[1] <= ZERO;
                        x_sh_q[2] <= ZERO - sext(sy_q);
                        y_sh_q[1] <= sext(cp_q);
                        z_sh_q[1] <= sext(sp_q);
                        y_sh_q[0] <= ZERO - mul_res;
                    end
                    2'd1: y_sh_q[2] <= ZERO - mul_res;
                    2'd2: z_sh_q[0] <= mul_res;
                    default: z_sh_q[2] <= mul_res;
                endcase
            end

            if (commit) begin
                x_vec <= x_sh_q;
                y_vec <= y_sh_q;
                z_vec <= z_sh_q;
            end
        end
    end

endmodule

// File: tb/tb_view_basis_sequencer.sv
// Bench for view_basis_sequencer: behavioural trig unit with programmable latency and a
// scoreboard of expected bases pushed when angles change and popped at each commit.
module tb_view_basis_sequencer;

    typedef struct packed {
        logic [2:0][31:0] x;
        logic [2:0][31:0] y;
        logic [2:0][31:0] z;
    } basis_t;

    logic              clk;
    logic              rst_n;
    logic [11:0]       yaw;
    logic [11:0]       pitch;
    logic              frame_start;
    logic              busy;
    logic              pending;
    logic [2:0][31:0]  x_vec, y_vec, z_vec;

    view_basis_sequencer_if #(.ROTATE_B(12), .TRIG_B(16)) trig_bus ();

    view_basis_sequencer #(
        .ROTATE_B        (12),
        .VECTOR_B        (32),
        .TRIG_B          (16),
        .FRAC            (14),
        .COMMIT_ON_FRAME (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .yaw         (yaw),
        .pitch       (pitch),
        .frame_start (frame_start),
        .trig        (trig_bus),
        .busy        (busy),
        .pending     (pending),
        .x_vec       (x_vec),
        .y_vec       (y_vec),
        .z_vec       (z_vec)
    );

    int     tests_run = 0;
    int     tests_failed = 0;
    int     cyc = 0;
    int     trig_lat = 3;
    int     spur_req = 0;
    int     spur_done = 0;
    bit     model_busy = 0;
    bit     prev_req = 0;
    int     consec_err = 0;
    int     outstanding_err = 0;
    int     req_cycles[$];
    int     ang_q[$];
    basis_t sb_q[$];
    basis_t ident;
    basis_t last_commit;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void trig_of(input int a, output int s, output int c);
        real ang;
        ang = 2.0 * 3.14159265358979 * real'(a) / 4096.0;
        s = int'(16384.0 * $sin(ang));
        c = int'(16384.0 * $cos(ang));
    endfunction

    function automatic basis_t model(input int yw, input int pt);
        basis_t b;
        int     sy, cy, sp, cp;
        longint p;
        trig_of(yw, sy, cy);
        trig_of(pt, sp, cp);
        b.x[0] = 32'(cy);
        b.x[1] = 32'd0;
        b.x[2] = 32'(-sy);
        p = (longint'(sp) * longint'(sy)) >>> 14;
        b.y[0] = 32'(-p);
        b.y[1] = 32'(cp);
        p = (longint'(sp) * longint'(cy)) >>> 14;
        b.y[2] = 32'(-p);
        p = (longint'(cp) * longint'(sy)) >>> 14;
        b.z[0] = 32'(p);
        b.z[1] = 32'(sp);
        p = (longint'(cp) * longint'(cy)) >>> 14;
        b.z[2] = 32'(p);
        return b;
    endfunction

    // Trig unit: answers each request trig_lat cycles later; can also inject a stray strobe.
    initial begin
        int a, s, c;
        trig_bus.trig_valid = 1'b0;
        trig_bus.trig_sin   = '0;
        trig_bus.trig_cos   = '0;
        @(posedge clk);
        #1;
        forever begin
            if (trig_bus.trig_req === 1'b1 && rst_n === 1'b1) begin
                a = int'(trig_bus.trig_angle);
                ang_q.push_back(a);
                @(posedge clk);
                #1;
                model_busy = 1'b1;
                repeat (trig_lat - 1) @(posedge clk);
                #1;
                trig_of(a, s, c);
                trig_bus.trig_sin   = 16'(s);
                trig_bus.trig_cos   = 16'(c);
                trig_bus.trig_valid = 1'b1;
                @(posedge clk);
                #1;
                trig_bus.trig_valid = 1'b0;
                model_busy = 1'b0;
            end else if (spur_done != spur_req) begin
                trig_bus.trig_sin   = 16'sh1234;
                trig_bus.trig_cos   = -16'sd999;
                trig_bus.trig_valid = 1'b1;
                @(posedge clk);
                #1;
                trig_bus.trig_valid = 1'b0;
                spur_done++;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && trig_bus.trig_req === 1'b1) begin
            req_cycles.push_back(cyc);
            if (prev_req) consec_err++;
            if (model_busy) outstanding_err++;
        end
        prev_req = (rst_n === 1'b1) && (trig_bus.trig_req === 1'b1);
    end

    task automatic wait_pending(output int pc, output bit ok);
        int n = 0;
        while (pending !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (pending === 1'b1);
        pc = cyc;
    endtask

    task automatic wait_reqs(input int target, output bit ok);
        int n = 0;
        while (req_cycles.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (req_cycles.size() >= target);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        yaw = '0;
        pitch = '0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = req_cycles.size();
        repeat (6) @(negedge clk);
        tests_run++;
        if (req_cycles.size() !== base) begin
            tests_failed++;
            $display("FAIL reset_no_req: got %0d requests, need 0", req_cycles.size() - base);
        end
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== ident) begin
            tests_failed++;
            $display("FAIL reset_identity: got %h need %h", {x_vec, y_vec, z_vec}, ident);
        end
        tests_run++;
        if (busy !== 1'b0 || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy=%b pending=%b need 0 0", busy, pending);
        end
        last_commit = ident;
    endtask

    task automatic test_rotate90();
        int base_r, base_a, t0, pc;
        bit ok;
        basis_t exp;
        logic [2:0][31:0] xe;
        @(negedge clk);
        base_r = req_cycles.size();
        base_a = ang_q.size();
        t0 = cyc;
        yaw = 12'd1024;
        pitch = 12'd0;
        sb_q.push_back(model(1024, 0));
        wait_pending(pc, ok);
        tests_run++;
        if (!ok || pc != t0 + 13) begin
            tests_failed++;
            $display("FAIL r90_pending_time: got cycle %0d (seen=%b) need %0d", pc - t0, ok, 13);
        end
        tests_run++;
        if (req_cycles.size() < base_r + 2 || req_cycles[base_r] != t0 + 1 ||
            req_cycles[base_r + 1] != t0 + 5) begin
            tests_failed++;
            $display("FAIL r90_req_time: got %0d reqs, first at +%0d, need +1 and +5",
                     req_cycles.size() - base_r,
                     (req_cycles.size() > base_r) ? req_cycles[base_r] - t0 : -1);
        end
        tests_run++;
        if (ang_q.size() < base_a + 2 || ang_q[base_a] != 1024 || ang_q[base_a + 1] != 0) begin
            tests_failed++;
            $display("FAIL r90_angles: got %0d angles, need 1024 then 0", ang_q.size() - base_a);
        end
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== last_commit || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL r90_precommit: got %h busy=%b need %h busy=0",
                     {x_vec, y_vec, z_vec}, busy, last_commit);
        end
        pulse_frame();
        tests_run++;
        if (pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL r90_pending_fall: got %b need 0", pending);
        end
        exp = sb_q.pop_front();
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== exp) begin
            tests_failed++;
            $display("FAIL r90_commit: got %h need %h", {x_vec, y_vec, z_vec}, exp);
        end
        xe[0] = 32'd0;
        xe[1] = 32'd0;
        xe[2] = -32'sd16384;
        tests_run++;
        if (x_vec !== xe) begin
            tests_failed++;
            $display("FAIL r90_x_literal: got %h need %h", x_vec, xe);
        end
        last_commit = exp;
    endtask

    task automatic test_hold_frame();
        int pc, bad;
        bit ok;
        basis_t exp;
        @(negedge clk);
        yaw = 12'd2048;
        pitch = 12'd0;
        sb_q.push_back(model(2048, 0));
        wait_pending(pc, ok);
        bad = ok ? 0 : 1;
        repeat (50) begin
            @(negedge clk);
            if (pending !== 1'b1 || {x_vec, y_vec, z_vec} !== last_commit) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_50: got %0d bad cycles need 0", bad);
        end
        pulse_frame();
        exp = sb_q.pop_front();
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== exp || pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_commit: got %h pending=%b need %h pending=0",
                     {x_vec, y_vec, z_vec}, pending, exp);
        end
        last_commit = exp;
    endtask

    task automatic test_change_in_wait();
        int base, pc, c_idle;
        bit ok;
        basis_t exp;
        @(negedge clk);
        base = req_cycles.size();
        yaw = 12'd512;
        pitch = 12'd256;
        sb_q.push_back(model(512, 256));
        wait_reqs(base + 2, ok);
        @(negedge clk);
        yaw = 12'd3072;
        sb_q.push_back(model(3072, 256));
        wait_pending(pc, ok);
        pulse_frame();
        c_idle = cyc;
        exp = sb_q.pop_front();
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== exp) begin
            tests_failed++;
            $display("FAIL chg_old_commit: got %h need %h", {x_vec, y_vec, z_vec}, exp);
        end
        wait_reqs(base + 3, ok);
        tests_run++;
        if (!ok || req_cycles[base + 2] != c_idle + 1) begin
            tests_failed++;
            $display("FAIL chg_restart: got req at +%0d (seen=%b) need +1",
                     ok ? req_cycles[base + 2] - c_idle : -1, ok);
        end
        wait_pending(pc, ok);
        pulse_frame();
        exp = sb_q.pop_front();
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== exp) begin
            tests_failed++;
            $display("FAIL chg_new_commit: got %h need %h", {x_vec, y_vec, z_vec}, exp);
        end
        last_commit = exp;
    endtask

    task automatic test_spurious();
        int base, pc;
        bit ok;
        basis_t exp;
        @(negedge clk);
        base = req_cycles.size();
        spur_req++;
        pulse_frame();
        repeat (6) @(negedge clk);
        tests_run++;
        if (req_cycles.size() != base || busy !== 1'b0 || pending !== 1'b0 ||
            {x_vec, y_vec, z_vec} !== last_commit) begin
            tests_failed++;
            $display("FAIL spur_idle: got reqs=%0d busy=%b pending=%b out=%h need 0 0 0 %h",
                     req_cycles.size() - base, busy, pending, {x_vec, y_vec, z_vec},
                     last_commit);
        end
        yaw = 12'd1024;
        pitch = 12'd1024;
        sb_q.push_back(model(1024, 1024));
        wait_reqs(base + 1, ok);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== last_commit || pending !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL spur_frame_wait: got %h pending=%b busy=%b need %h 0 1",
                     {x_vec, y_vec, z_vec}, pending, busy, last_commit);
        end
        wait_pending(pc, ok);
        pulse_frame();
        exp = sb_q.pop_front();
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== exp) begin
            tests_failed++;
            $display("FAIL spur_commit: got %h need %h", {x_vec, y_vec, z_vec}, exp);
        end
        last_commit = exp;
    endtask

    task automatic test_back_to_back();
        int t0, pc, ny, np;
        bit ok;
        basis_t exp;
        for (int i = 0; i < 4; i++) begin
            trig_lat = 1 + i;
            do begin
                ny = int'($urandom_range(0, 4095));
                np = int'($urandom_range(0, 4095));
            end while (ny == int'(yaw) && np == int'(pitch));
            @(negedge clk);
            t0 = cyc;
            yaw = 12'(ny);
            pitch = 12'(np);
            sb_q.push_back(model(ny, np));
            wait_pending(pc, ok);
            tests_run++;
            if (!ok || pc != t0 + 7 + 2 * trig_lat) begin
                tests_failed++;
                $display("FAIL b2b_timing L=%0d: got +%0d need +%0d",
                         trig_lat, pc - t0, 7 + 2 * trig_lat);
            end
            pulse_frame();
            exp = sb_q.pop_front();
            tests_run++;
            if ({x_vec, y_vec, z_vec} !== exp) begin
                tests_failed++;
                $display("FAIL b2b_commit y=%0d p=%0d: got %h need %h",
                         ny, np, {x_vec, y_vec, z_vec}, exp);
            end
            last_commit = exp;
        end
        trig_lat = 3;
        tests_run++;
        if (consec_err != 0 || outstanding_err != 0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL req_protocol: got consec=%0d outstanding=%0d left=%0d need 0 0 0",
                     consec_err, outstanding_err, sb_q.size());
        end
    endtask

    task automatic test_reset_in_mul();
        int base;
        bit ok;
        @(negedge clk);
        base = req_cycles.size();
        yaw = 12'd0;
        pitch = 12'd0;
        wait_reqs(base + 2, ok);
        if (ok) begin
            while (cyc < req_cycles[base + 1] + trig_lat + 2) @(negedge clk);
        end
        tests_run++;
        if (!ok || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mul_setup: got busy=%b seen=%b need 1 1", busy, ok);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({x_vec, y_vec, z_vec} !== ident || pending !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mul_async: got %h pending=%b busy=%b need %h 0 0",
                     {x_vec, y_vec, z_vec}, pending, busy, ident);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = req_cycles.size();
        repeat (10) @(negedge clk);
        tests_run++;
        if (req_cycles.size() != base || {x_vec, y_vec, z_vec} !== ident) begin
            tests_failed++;
            $display("FAIL rst_mul_release: got reqs=%0d out=%h need 0 %h",
                     req_cycles.size() - base, {x_vec, y_vec, z_vec}, ident);
        end
    endtask

    initial begin
        ident = '0;
        ident.x[0] = 32'd16384;
        ident.y[1] = 32'd16384;
        ident.z[2] = 32'd16384;
        test_reset();
        test_rotate90();
        test_hold_frame();
        test_change_in_wait();
        test_spurious();
        test_back_to_back();
        test_reset_in_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
